// File: rtl/div_result_bcd.sv
// Converts a signed quotient/remainder pair to sign + packed BCD magnitude using a
// sequential shift-add-3 engine; one conversion in flight, valid/ready on both sides.
module div_result_bcd #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      quotient,
    input  logic [WIDTH-1:0]      remainder,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  q_neg,
    output logic [4*DIGITS-1:0]   q_bcd,
    output logic                  r_neg,
    output logic [4*DIGITS-1:0]   r_bcd
);

    localparam int unsigned BW   = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_t;

    state_t              state;
    logic [CntW-1:0]     count;
    logic [WIDTH-1:0]    q_mag, r_mag;
    logic [BW-1:0]       q_work, r_work;
    logic                q_sign, r_sign;

    logic [BW-1:0]       q_adj, r_adj, q_next, r_next;
    logic [WIDTH-1:0]    q_abs, r_abs;

    function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
        logic [BW-1:0] res;
        res = b;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

    always_comb begin
        q_adj  = add3(q_work);
        r_adj  = add3(r_work);
        // Magnitude MSB shifts into BCD bit 0; the adjusted top bit falls off (never set).
        q_next = BW'({q_adj, q_mag[WIDTH-1]});
        r_next = BW'({r_adj, r_mag[WIDTH-1]});
        // Negation within WIDTH bits: the most negative value maps to 2^(WIDTH-1).
        q_abs  = quotient[WIDTH-1]  ? -quotient  : quotient;
        r_abs  = remainder[WIDTH-1] ? -remainder : remainder;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            q_bcd     <= '0;
            r_bcd     <= '0;
            count     <= '0;
            q_mag     <= '0;
            r_mag     <= '0;
            q_work    <= '0;
            r_work    <= '0;
            q_sign    <= 1'b0;
            r_sign    <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        q_sign   <= quotient[WIDTH-1];
                        r_sign   <= remainder[WIDTH-1];
                        q_mag    <= q_abs;
                        r_mag    <= r_abs;
                        q_work   <= '0;
                        r_work   <= '0;
                        count    <= '0;
                        in_ready <= 1'b0;
                        state    <= StConv;
                    end
                end
                StConv: begin
                    q_work <= q_next;
                    r_work <= r_next;
                    q_mag  <= q_mag << 1;
                    r_mag  <= r_mag << 1;
                    count  <= count + CntW'(1);
                    if (count == CntW'(WIDTH - 1)) begin
                        q_bcd     <= q_next;
                        r_bcd     <= r_next;
                        q_neg     <= q_sign;
                        r_neg     <= r_sign;
                        out_valid <= 1'b1;
                        state     <= StDone;
                    end
                end
                StDone: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: begin
                    state     <= StIdle;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
